// File: rtl/turf_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : turf_reg_arbiter
//  Description : Round-robin arbiter that shares the single TURF register
//                interface master (wr/rd/addr/bank/dat/ack) between NREQ
//                requesters. It latches the winning command for the whole
//                transaction, routes ack and read data back to the winner,
//                and aborts with an error flag if the TURF side never acks.
//  Revision    : 1.0 - initial release
// ============================================================================
module turf_reg_arbiter #(
    parameter int          NREQ     = 2,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_wr_i,
    input  logic [NREQ-1:0]      req_rd_i,
    input  logic [6*NREQ-1:0]    req_addr_i,
    input  logic [2*NREQ-1:0]    req_bank_i,
    input  logic [32*NREQ-1:0]   req_dat_i,
    output logic [31:0]          req_dat_o,
    output logic [NREQ-1:0]      req_ack_o,
    output logic [NREQ-1:0]      req_err_o,
    output logic                 if_wr_o,
    output logic                 if_rd_o,
    output logic [5:0]           if_addr_o,
    output logic [1:0]           if_bank_o,
    output logic [31:0]          if_dat_o,
    input  logic [31:0]          if_dat_i,
    input  logic                 if_ack_i,
    output logic                 busy_o,
    output logic [1:0]           grant_o
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_ISSUE = 2'd1;
    localparam logic [1:0]  S_WAIT  = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;

    // Last WAIT count value before the transaction is declared dead.
    localparam logic [15:0] c_cnt_last = 16'(TIMEOUT - 1);

    // Registered state and outputs
    logic [1:0]  r_state;
    logic [1:0]  r_ptr;
    logic [1:0]  r_grant;
    logic        r_is_wr;
    logic [15:0] r_cnt;
    logic        r_if_wr;
    logic        r_if_rd;
    logic [5:0]  r_if_addr;
    logic [1:0]  r_if_bank;
    logic [31:0] r_if_dat;
    logic [31:0] r_req_dat;
    logic [NREQ-1:0] r_req_ack;
    logic [NREQ-1:0] r_req_err;

    // Requester fields widened to four slots so a 2-bit index is always legal
    logic [3:0]  w_req4;
    logic [3:0]  w_wr4;
    logic [5:0]  w_addr_a [4];
    logic [1:0]  w_bank_a [4];
    logic [31:0] w_dat_a  [4];

    logic        w_any;
    logic [1:0]  w_sel;
    logic [2:0]  w_sum;
    logic [1:0]  w_next_ptr;
    logic [3:0]  w_grant_1h;

    // Unpack the flat per-requester buses; a write strobe wins over read.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_req4[k]   = 1'b0;
            w_wr4[k]    = 1'b0;
            w_addr_a[k] = 6'd0;
            w_bank_a[k] = 2'd0;
            w_dat_a[k]  = 32'd0;
        end
        for (int k = 0; k < NREQ; k++) begin
            w_req4[k]   = req_wr_i[k] | req_rd_i[k];
            w_wr4[k]    = req_wr_i[k];
            w_addr_a[k] = req_addr_i[6*k +: 6];
            w_bank_a[k] = req_bank_i[2*k +: 2];
            w_dat_a[k]  = req_dat_i[32*k +: 32];
        end
    end

    // Round-robin pick: first active requester at or above the pointer.
    always_comb begin
        w_any = 1'b0;
        w_sel = 2'd0;
        w_sum = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, r_ptr} + 3'(i);
            if (w_sum >= 3'(NREQ)) begin
                w_sum = w_sum - 3'(NREQ);
            end
            if (!w_any && w_req4[w_sum[1:0]]) begin
                w_any = 1'b1;
                w_sel = w_sum[1:0];
            end
        end
    end

    // Pointer advance past the winner and one-hot of the current grant.
    always_comb begin
        w_next_ptr = (w_sel == 2'(NREQ - 1)) ? 2'd0 : w_sel + 2'd1;
        w_grant_1h = 4'b0001 << r_grant;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'd0;
            r_grant   <= 2'd0;
            r_is_wr   <= 1'b0;
            r_cnt     <= 16'd0;
            r_if_wr   <= 1'b0;
            r_if_rd   <= 1'b0;
            r_if_addr <= 6'd0;
            r_if_bank <= 2'd0;
            r_if_dat  <= 32'd0;
            r_req_dat <= 32'd0;
            r_req_ack <= '0;
            r_req_err <= '0;
        end else begin
            // Completion flags are single-cycle pulses.
            r_req_ack <= '0;
            r_req_err <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_sel;
                        r_ptr     <= w_next_ptr;
                        r_is_wr   <= w_wr4[w_sel];
                        r_if_addr <= w_addr_a[w_sel];
                        r_if_bank <= w_bank_a[w_sel];
                        r_if_dat  <= w_dat_a[w_sel];
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_if_wr <= r_is_wr;
                    r_if_rd <= ~r_is_wr;
                    r_cnt   <= 16'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (if_ack_i) begin
                        r_if_wr   <= 1'b0;
                        r_if_rd   <= 1'b0;
                        r_req_dat <= r_is_wr ? 32'd0 : if_dat_i;
                        r_req_ack <= w_grant_1h[NREQ-1:0];
                        r_state   <= S_DONE;
                    end else if (r_cnt == c_cnt_last) begin
                        r_if_wr   <= 1'b0;
                        r_if_rd   <= 1'b0;
                        r_req_dat <= r_is_wr ? 32'd0 : ERR_DATA;
                        r_req_ack <= w_grant_1h[NREQ-1:0];
                        r_req_err <= w_grant_1h[NREQ-1:0];
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    // Hold here while a (possibly late) ack is still high.
                    if (!if_ack_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_dat_o = r_req_dat;
    assign req_ack_o = r_req_ack;
    assign req_err_o = r_req_err;
    assign if_wr_o   = r_if_wr;
    assign if_rd_o   = r_if_rd;
    assign if_addr_o = r_if_addr;
    assign if_bank_o = r_if_bank;
    assign if_dat_o  = r_if_dat;
    assign busy_o    = (r_state != S_IDLE);
    assign grant_o   = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_turf_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turf_reg_arbiter
//  Description : Directed, table-driven bench for turf_reg_arbiter (NREQ=2,
//                TIMEOUT=16) with hand-written late-ack and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_turf_reg_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req_wr_i = '0;
    logic [1:0]  req_rd_i = '0;
    logic [11:0] req_addr_i = '0;
    logic [3:0]  req_bank_i = '0;
    logic [63:0] req_dat_i = '0;
    logic [31:0] req_dat_o;
    logic [1:0]  req_ack_o;
    logic [1:0]  req_err_o;
    logic        if_wr_o;
    logic        if_rd_o;
    logic [5:0]  if_addr_o;
    logic [1:0]  if_bank_o;
    logic [31:0] if_dat_o;
    logic [31:0] if_dat_i = '0;
    logic        if_ack_i = 1'b0;
    logic        busy_o;
    logic [1:0]  grant_o;

    int n_cmp = 0;
    int n_bad = 0;

    turf_reg_arbiter #(
        .NREQ     (2),
        .TIMEOUT  (16),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_wr_i   (req_wr_i),
        .req_rd_i   (req_rd_i),
        .req_addr_i (req_addr_i),
        .req_bank_i (req_bank_i),
        .req_dat_i  (req_dat_i),
        .req_dat_o  (req_dat_o),
        .req_ack_o  (req_ack_o),
        .req_err_o  (req_err_o),
        .if_wr_o    (if_wr_o),
        .if_rd_o    (if_rd_o),
        .if_addr_o  (if_addr_o),
        .if_bank_o  (if_bank_o),
        .if_dat_o   (if_dat_o),
        .if_dat_i   (if_dat_i),
        .if_ack_i   (if_ack_i),
        .busy_o     (busy_o),
        .grant_o    (grant_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;      // pulse reset before applying
        logic [1:0]  wr;
        logic [1:0]  rd;
        logic [11:0] addr;     // {req1, req0}
        logic [3:0]  bank;
        logic [63:0] dat;
        int          delay;    // strobe cycles before ack; 0 = never ack
        logic [31:0] rdata;    // model read data
        logic [1:0]  eg;
        logic        ewr;
        logic        erd;
        logic [5:0]  eaddr;
        logic [1:0]  ebank;
        logic [31:0] edat;
        logic [1:0]  eack;
        logic [1:0]  eerr;
        logic [31:0] erdat;
        int          estb;     // expected number of strobe-high cycles
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] wr, input logic [1:0] rd, input logic [11:0] addr,
                         input logic [3:0] bank, input logic [63:0] dat);
        req_wr_i   = wr;
        req_rd_i   = rd;
        req_addr_i = addr;
        req_bank_i = bank;
        req_dat_i  = dat;
    endtask

    // Wait for the strobe, act as the TURF slave, then check completion.
    task automatic run_txn(input string tag, input int delay, input logic [31:0] rdata,
                           input logic [1:0] eg, input logic ewr, input logic erd,
                           input logic [5:0] eaddr, input logic [1:0] ebank,
                           input logic [31:0] edat, input logic [1:0] eack,
                           input logic [1:0] eerr, input logic [31:0] erdat, input int estb);
        bit          seen;
        bit          got;
        bit          stable;
        int          n;
        logic [41:0] snap;
        seen = 0;
        if_dat_i = rdata;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk_i);
            if (if_wr_o || if_rd_o) seen = 1;
        end
        chk({tag, " strobe_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        chk({tag, " grant"}, 32'(grant_o), 32'(eg));
        chk({tag, " if_wr"}, 32'(if_wr_o), 32'(ewr));
        chk({tag, " if_rd"}, 32'(if_rd_o), 32'(erd));
        chk({tag, " if_addr"}, 32'(if_addr_o), 32'(eaddr));
        chk({tag, " if_bank"}, 32'(if_bank_o), 32'(ebank));
        chk({tag, " if_dat"}, if_dat_o, edat);
        snap = {if_wr_o, if_rd_o, if_addr_o, if_bank_o, if_dat_o};
        stable = 1;
        got = 0;
        n = 1;
        for (int c = 0; c < 40; c++) begin
            if (n == delay) if_ack_i = 1'b1;
            @(negedge clk_i);
            if (req_ack_o != 2'b00) begin
                got = 1;
                break;
            end
            if ({if_wr_o, if_rd_o, if_addr_o, if_bank_o, if_dat_o} != snap) stable = 0;
            n++;
        end
        if_ack_i = 1'b0;
        chk({tag, " ack_seen"}, 32'(got), 32'd1);
        chk({tag, " fields_stable"}, 32'(stable), 32'd1);
        chk({tag, " strobe_cycles"}, 32'(n), 32'(estb));
        chk({tag, " req_ack"}, 32'(req_ack_o), 32'(eack));
        chk({tag, " req_err"}, 32'(req_err_o), 32'(eerr));
        chk({tag, " req_dat"}, req_dat_o, erdat);
        chk({tag, " strobes_low"}, 32'({if_wr_o, if_rd_o}), 32'd0);
        chk({tag, " busy_done"}, 32'(busy_o), 32'd1);
    endtask

    // Bound the whole run so a stuck design still reaches a verdict.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // rst  wr     rd     addr{r1,r0}         bank     dat{r1,r0}                    dly rdata         eg  wr rd addr   bank   edat          eack   eerr   erdat         stb
        vt[0] = '{1'b1, 2'b01, 2'b00, {6'h00, 6'h08}, 4'b0010, {32'h0, 32'h01234567},        3, 32'h0,        2'd0, 1'b1, 1'b0, 6'h08, 2'b10, 32'h01234567, 2'b01, 2'b00, 32'h0,        3};
        vt[1] = '{1'b0, 2'b00, 2'b10, {6'h00, 6'h00}, 4'b0000, {32'h0, 32'h0},               2, 32'hCAFEF00D, 2'd1, 1'b0, 1'b1, 6'h00, 2'b00, 32'h0,        2'b10, 2'b00, 32'hCAFEF00D, 2};
        vt[2] = '{1'b0, 2'b10, 2'b10, {6'h2A, 6'h00}, 4'b1100, {32'hA5A50F0F, 32'h0},        1, 32'h77777777, 2'd1, 1'b1, 1'b0, 6'h2A, 2'b11, 32'hA5A50F0F, 2'b10, 2'b00, 32'h0,        1};
        vt[3] = '{1'b1, 2'b10, 2'b01, {6'h22, 6'h11}, 4'b1001, {32'h11112222, 32'h33334444}, 2, 32'h12345678, 2'd0, 1'b0, 1'b1, 6'h11, 2'b01, 32'h33334444, 2'b01, 2'b00, 32'h12345678, 2};
        vt[4] = '{1'b0, 2'b10, 2'b01, {6'h22, 6'h11}, 4'b1001, {32'h11112222, 32'h33334444}, 4, 32'h0,        2'd1, 1'b1, 1'b0, 6'h22, 2'b10, 32'h11112222, 2'b10, 2'b00, 32'h0,        4};
        vt[5] = '{1'b0, 2'b10, 2'b01, {6'h22, 6'h11}, 4'b1001, {32'h11112222, 32'h33334444}, 1, 32'h9ABCDEF0, 2'd0, 1'b0, 1'b1, 6'h11, 2'b01, 32'h33334444, 2'b01, 2'b00, 32'h9ABCDEF0, 1};
        vt[6] = '{1'b0, 2'b10, 2'b01, {6'h22, 6'h11}, 4'b1001, {32'h11112222, 32'h33334444}, 2, 32'h0,        2'd1, 1'b1, 1'b0, 6'h22, 2'b10, 32'h11112222, 2'b10, 2'b00, 32'h0,        2};
        vt[7] = '{1'b0, 2'b10, 2'b00, {6'h3C, 6'h11}, 4'b0101, {32'hFEEDFACE, 32'h0},        0, 32'h0,        2'd1, 1'b1, 1'b0, 6'h3C, 2'b01, 32'hFEEDFACE, 2'b10, 2'b10, 32'h0,        16};

        // Table: single write, single read, wr+rd, contention from reset, write timeout.
        for (int i = 0; i < 8; i++) begin
            if (vt[i].rst) begin
                rst_i = 1'b1;
                @(negedge clk_i);
                rst_i = 1'b0;
                chk($sformatf("v%0d reset_busy", i), 32'(busy_o), 32'd0);
                chk($sformatf("v%0d reset_outs", i),
                    32'({req_ack_o, req_err_o, if_wr_o, if_rd_o, grant_o}), 32'd0);
                chk($sformatf("v%0d reset_dat", i), req_dat_o, 32'd0);
            end
            drive(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].bank, vt[i].dat);
            run_txn($sformatf("v%0d", i), vt[i].delay, vt[i].rdata, vt[i].eg, vt[i].ewr,
                    vt[i].erd, vt[i].eaddr, vt[i].ebank, vt[i].edat, vt[i].eack,
                    vt[i].eerr, vt[i].erdat, vt[i].estb);
            @(negedge clk_i);
            chk($sformatf("v%0d gap_idle", i), 32'(busy_o), 32'd0);
            chk($sformatf("v%0d ack_one_cycle", i), 32'({req_ack_o, req_err_o}), 32'd0);
        end

        // Read timeout on requester 0 followed by a late ack held 5 cycles.
        drive(2'b00, 2'b01, {6'h00, 6'h05}, 4'b0010, 64'h0);
        run_txn("tmo_rd", 0, 32'h0, 2'd0, 1'b0, 1'b1, 6'h05, 2'b10, 32'h0,
                2'b01, 2'b01, 32'hDEADBEEF, 16);
        drive(2'b00, 2'b00, 12'h0, 4'h0, 64'h0);
        if_ack_i = 1'b1;
        ok = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (!busy_o || req_ack_o != 2'b00 || req_err_o != 2'b00 || if_wr_o || if_rd_o) ok = 0;
        end
        chk("late_ack held_in_done", 32'(ok), 32'd1);
        if_ack_i = 1'b0;
        @(negedge clk_i);
        chk("late_ack released", 32'(busy_o), 32'd0);

        // Reset during WAIT abandons the write; next contention grants requester 0.
        drive(2'b10, 2'b00, {6'h0A, 6'h00}, 4'b0000, {32'hAAAA5555, 32'h0});
        ok = 0;
        for (int c = 0; c < 12 && !ok; c++) begin
            @(negedge clk_i);
            if (if_wr_o) ok = 1;
        end
        chk("rst_mid strobe_seen", 32'(ok), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_mid strobes", 32'({if_wr_o, if_rd_o}), 32'd0);
        chk("rst_mid busy", 32'(busy_o), 32'd0);
        chk("rst_mid ack_err", 32'({req_ack_o, req_err_o}), 32'd0);
        drive(2'b10, 2'b01, {6'h0A, 6'h01}, 4'b0011, {32'hAAAA5555, 32'h0});
        run_txn("rst_mid next", 2, 32'h0BADF00D, 2'd0, 1'b0, 1'b1, 6'h01, 2'b11, 32'h0,
                2'b01, 2'b00, 32'h0BADF00D, 2);
        drive(2'b00, 2'b00, 12'h0, 4'h0, 64'h0);
        @(negedge clk_i);
        chk("final idle", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
